// File: rtl/hough_pkg.sv
// Shared types and fixed-point constants for the Hough line raster.
package hough_pkg;

    // Signed pixel coordinate width.
    localparam int COORD_W = 12;
    // Signed sin/cos width, Q2.(TRIG_W-2).
    localparam int TRIG_W  = 16;
    // Fractional bits of sin/cos; 1.0 == 2**FRAC.
    localparam int FRAC    = 14;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [TRIG_W-1:0]  trig_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SWEEP,
        FLUSH,
        DONE
    } raster_state_t;

endpackage

// File: rtl/hough_coord_round.sv
// Turns a fixed-point accumulator into a rounded pixel coordinate (round half
// up) and flags whether that coordinate lies inside 0..LIMIT.
module hough_coord_round
    import hough_pkg::*;
#(
    parameter int ACC_W = COORD_W + FRAC + 12,
    parameter int LIMIT = 1000
) (
    input  logic signed [ACC_W-1:0] acc,
    output coord_t                  coord,
    output logic                    in_range
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] LIM  = ACC_W'(LIMIT);

    logic signed [ACC_W-1:0] rounded;

    // Arithmetic shift floors, so adding one half first rounds half up,
    // including for negative accumulators.
    assign rounded  = (acc + HALF) >>> FRAC;
    // The full-width value is range-checked so that far-off-image points
    // cannot alias into the image through truncation.
    assign in_range = (rounded[ACC_W-1] == 1'b0) && (rounded <= LIM);
    assign coord    = rounded[COORD_W-1:0];

endmodule

// File: rtl/hough_line_raster.sv
// Rasterises one detected Hough line: sweeps j over [J_MIN,J_MAX], generates
// x = x0 - j*sin, y = y0 + j*cos, clips to the image, drops consecutive
// duplicates and streams pixels over a valid/ready interface.
module hough_line_raster
    import hough_pkg::*;
#(
    parameter int J_W   = 12,
    parameter int J_MIN = -1000,
    parameter int J_MAX = 1000,
    parameter int X_MAX = 1000,
    parameter int Y_MAX = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_valid,
    output logic                      line_ready,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [TRIG_W-1:0]  cos,
    input  logic signed [TRIG_W-1:0]  sin,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [COORD_W-1:0]        pix_x,
    output logic [COORD_W-1:0]        pix_y,
    output logic                      busy,
    output logic                      line_done,
    output logic [15:0]               pix_count
);

    localparam int ACC_W = COORD_W + FRAC + J_W;

    localparam logic signed [ACC_W-1:0] J_MIN_ACC = ACC_W'(J_MIN);
    localparam logic signed [J_W-1:0]   J_FIRST   = J_W'(J_MIN);
    localparam logic signed [J_W-1:0]   J_LAST    = J_W'(J_MAX);

    raster_state_t           state;
    coord_t                  x0_r, y0_r;
    trig_t                   cos_r, sin_r;
    logic signed [ACC_W-1:0] ax, ay;
    logic signed [J_W-1:0]   j;
    logic                    has_last;

    coord_t cand_x, cand_y;
    logic   x_in, y_in;
    logic   stall, is_new, emit;

    hough_coord_round #(.ACC_W(ACC_W), .LIMIT(X_MAX)) u_round_x (
        .acc      (ax),
        .coord    (cand_x),
        .in_range (x_in)
    );

    hough_coord_round #(.ACC_W(ACC_W), .LIMIT(Y_MAX)) u_round_y (
        .acc      (ay),
        .coord    (cand_y),
        .in_range (y_in)
    );

    // The held pixel doubles as the last-emitted pixel for duplicate removal.
    assign stall  = pix_valid & ~pix_ready;
    assign is_new = ~has_last | (cand_x != pix_x) | (cand_y != pix_y);
    assign emit   = x_in & y_in & is_new;

    // Status decoded straight from the state so line_ready rises in the very
    // first cycle after reset is released.
    assign line_ready = (state == IDLE) & ~reset;
    assign busy       = (state != IDLE);
    assign line_done  = (state == DONE);

    // Line FSM, sweep accumulators and pixel output register.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_count <= '0;
            has_last  <= 1'b0;
            x0_r      <= '0;
            y0_r      <= '0;
            cos_r     <= '0;
            sin_r     <= '0;
            ax        <= '0;
            ay        <= '0;
            j         <= J_FIRST;
        end else begin
            case (state)
                IDLE: begin
                    if (line_valid) begin
                        x0_r      <= x0;
                        y0_r      <= y0;
                        cos_r     <= cos;
                        sin_r     <= sin;
                        pix_count <= '0;
                        has_last  <= 1'b0;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    ax    <= (ACC_W'(x0_r) <<< FRAC) - J_MIN_ACC * ACC_W'(sin_r);
                    ay    <= (ACC_W'(y0_r) <<< FRAC) + J_MIN_ACC * ACC_W'(cos_r);
                    j     <= J_FIRST;
                    state <= SWEEP;
                end
                SWEEP: begin
                    if (!stall) begin
                        if (emit) begin
                            pix_x     <= cand_x;
                            pix_y     <= cand_y;
                            pix_valid <= 1'b1;
                            pix_count <= pix_count + 16'd1;
                            has_last  <= 1'b1;
                        end else begin
                            pix_valid <= 1'b0;
                        end
                        if (j == J_LAST) begin
                            state <= FLUSH;
                        end else begin
                            ax <= ax - ACC_W'(sin_r);
                            ay <= ay + ACC_W'(cos_r);
                            j  <= j + J_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!pix_valid) begin
                        state <= DONE;
                    end else if (pix_ready) begin
                        pix_valid <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hough_line_raster.sv
// Self-checking bench for hough_line_raster: directed lines plus random lines
// compared against a direct-formula reference model.
module tb_hough_line_raster;

    localparam int COORD_W = 12;
    localparam int TRIG_W  = 16;
    localparam int J_MIN   = -1000;
    localparam int J_MAX   = 1000;
    localparam int X_MAX   = 1000;
    localparam int Y_MAX   = 1000;
    localparam int BUDGET  = 10000;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      line_valid = 1'b0;
    logic                      line_ready;
    logic signed [COORD_W-1:0] x0 = '0;
    logic signed [COORD_W-1:0] y0 = '0;
    logic signed [TRIG_W-1:0]  cos_i = '0;
    logic signed [TRIG_W-1:0]  sin_i = '0;
    logic                      pix_valid;
    logic                      pix_ready = 1'b0;
    logic [COORD_W-1:0]        pix_x, pix_y;
    logic                      busy, line_done;
    logic [15:0]               pix_count;

    int vectors     = 0;
    int miscompares = 0;

    int exp_x[$];
    int exp_y[$];

    hough_line_raster dut (
        .clk        (clk),
        .reset      (reset),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .x0         (x0),
        .y0         (y0),
        .cos        (cos_i),
        .sin        (sin_i),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .busy       (busy),
        .line_done  (line_done),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expected);
        end
    endtask

    // Reference: evaluate every sweep point directly from the line equation,
    // round half up, clip, and drop repeats of the previous kept pixel.
    function automatic void build_expected(input int x, input int y,
                                           input int c, input int s);
        longint lx, ly;
        bit     have;
        exp_x.delete();
        exp_y.delete();
        have = 1'b0;
        lx   = 0;
        ly   = 0;
        for (int jj = J_MIN; jj <= J_MAX; jj++) begin
            longint fx, fy, px, py;
            fx = longint'(x) * 16384 - longint'(jj) * longint'(s);
            fy = longint'(y) * 16384 + longint'(jj) * longint'(c);
            px = (fx + 8192) >>> 14;
            py = (fy + 8192) >>> 14;
            if (px >= 0 && px <= X_MAX && py >= 0 && py <= Y_MAX &&
                !(have && px == lx && py == ly)) begin
                exp_x.push_back(int'(px));
                exp_y.push_back(int'(py));
                lx   = px;
                ly   = py;
                have = 1'b1;
            end
        end
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 1) return (k % 3 == 0);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    // Runs one line. abort_after>0 asserts reset right after that many pixels;
    // exp_done_k / exp_first_k >= 0 check cycle offsets from the accept edge.
    task automatic run_line(input string name, input int x, input int y,
                            input int c, input int s, input int rmode,
                            input int abort_after, input bit hold_valid,
                            input int exp_done_k, input int exp_first_k);
        int               k, idx, first_k, ready_busy;
        bit               done, stall_prev;
        logic [COORD_W-1:0] hx, hy;

        build_expected(x, y, c, s);
        @(negedge clk);
        check({name, "/ready_idle"}, line_ready, 1);
        x0         = COORD_W'(x);
        y0         = COORD_W'(y);
        cos_i      = TRIG_W'(c);
        sin_i      = TRIG_W'(s);
        line_valid = 1'b1;
        pix_ready  = ready_for(rmode, 0);
        @(posedge clk);
        #1;
        if (!hold_valid) line_valid = 1'b0;

        k          = 0;
        idx        = 0;
        first_k    = -1;
        ready_busy = 0;
        done       = 1'b0;
        stall_prev = 1'b0;
        hx         = '0;
        hy         = '0;

        while (!done && k < BUDGET) begin
            @(negedge clk);
            if (pix_valid) begin
                if (first_k < 0) first_k = k;
                if (stall_prev) begin
                    check({name, "/stall_x"}, pix_x, hx);
                    check({name, "/stall_y"}, pix_y, hy);
                end
                if (pix_ready) begin
                    if (idx < exp_x.size()) begin
                        check({name, "/pix_x"}, pix_x, exp_x[idx]);
                        check({name, "/pix_y"}, pix_y, exp_y[idx]);
                    end else begin
                        check({name, "/extra_pixel"}, idx, exp_x.size());
                    end
                    idx++;
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    hx = pix_x;
                    hy = pix_y;
                end
            end else if (stall_prev) begin
                check({name, "/dropped_in_stall"}, pix_valid, 1);
                stall_prev = 1'b0;
            end
            if (busy && line_ready) ready_busy++;
            if (line_done) begin
                done = 1'b1;
                if (hold_valid) line_valid = 1'b0;
                check({name, "/pix_count"}, pix_count, exp_x.size());
                check({name, "/pixels_seen"}, idx, exp_x.size());
                if (exp_done_k >= 0) check({name, "/done_latency"}, k, exp_done_k);
            end
            if (abort_after > 0 && !done && idx == abort_after) begin
                @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                check({name, "/abort_pix_valid"}, pix_valid, 0);
                check({name, "/abort_line_done"}, line_done, 0);
                check({name, "/abort_busy"}, busy, 0);
                check({name, "/abort_pix_count"}, pix_count, 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                check({name, "/abort_no_done"}, line_done, 0);
                check({name, "/abort_ready"}, line_ready, 1);
                return;
            end
            if (!done) begin
                @(posedge clk);
                #1;
                k++;
                pix_ready = ready_for(rmode, k);
            end
        end

        check({name, "/line_done_seen"}, done, 1);
        check({name, "/ready_while_busy"}, ready_busy, 0);
        if (exp_first_k >= 0) check({name, "/first_latency"}, first_k, exp_first_k);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "/done_pulse"}, line_done, 0);
        check({name, "/idle_busy"}, busy, 0);
        check({name, "/idle_ready"}, line_ready, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/line_ready", line_ready, 0);
        check("reset/pix_valid", pix_valid, 0);
        check("reset/pix_x", pix_x, 0);
        check("reset/pix_y", pix_y, 0);
        check("reset/busy", busy, 0);
        check("reset/line_done", line_done, 0);
        check("reset/pix_count", pix_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset/ready_after", line_ready, 1);

        run_line("vertical",   500, 500, 16384, 0,     0, 0,  1'b0, -1, -1);
        run_line("horizontal", 0,   10,  0,     16384, 0, 0,  1'b0, -1, 2);
        run_line("stalled",    500, 500, 16384, 0,     1, 0,  1'b0, -1, -1);
        run_line("diagonal",   500, 500, 11585, 11585, 2, 0,  1'b0, -1, -1);
        run_line("offimage",   2000, 500, 16384, 0,    0, 0,  1'b1, 2003, -1);
        run_line("abort",      500, 500, 16384, 0,     0, 10, 1'b0, -1, -1);
        run_line("after_abort", 500, 500, 16384, 0,    0, 0,  1'b0, -1, -1);

        for (int n = 0; n < 3; n++) begin
            int rx, ry, rc, rs;
            rx = int'($urandom_range(0, 1600)) - 300;
            ry = int'($urandom_range(0, 1600)) - 300;
            rc = int'($urandom_range(0, 32768)) - 16384;
            rs = int'($urandom_range(0, 32768)) - 16384;
            run_line($sformatf("random%0d", n), rx, ry, rc, rs, 2, 0, 1'b0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
